// File: rtl/weight_read_sequencer_pkg.sv
// Shared types and sizing helpers for the weight read sequencer and its index counter.
package weight_read_sequencer_pkg;

    typedef enum logic [1:0] {
        WRS_IDLE  = 2'd0,
        WRS_RUN   = 2'd1,
        WRS_DRAIN = 2'd2,
        WRS_DONE  = 2'd3
    } wrs_state_e;

    // Index width for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int unsigned wrs_cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned WRS_DEFAULT_NUM_WEIGHT = 3;
    localparam int unsigned WRS_DEFAULT_COUNT_W    = wrs_cnt_width(WRS_DEFAULT_NUM_WEIGHT);

endpackage

// File: rtl/weight_read_sequencer_if.sv
// Bundle of the sequencer's stream, weight-memory and MAC-side signals.
// WRS_BACKPRESSURE_EN adds mac_ready from the MAC.
interface weight_read_sequencer_if
    import weight_read_sequencer_pkg::*;
#(
    parameter int unsigned dataWidth    = 16,
    parameter int unsigned addressWidth = 10
);
    logic                    in_valid;
    logic [dataWidth-1:0]    in_data;
    logic                    in_ready;
    logic                    ren;
    logic [addressWidth-1:0] raddr;
    logic [dataWidth-1:0]    x_out;
    logic                    mac_valid;
    logic                    mac_last;
    logic                    neuron_done;
    logic                    busy;
`ifdef WRS_BACKPRESSURE_EN
    logic                    mac_ready;

    modport master (
        input  in_valid, in_data, mac_ready,
        output in_ready, ren, raddr, x_out, mac_valid, mac_last, neuron_done, busy
    );
    modport slave (
        output in_valid, in_data, mac_ready,
        input  in_ready, ren, raddr, x_out, mac_valid, mac_last, neuron_done, busy
    );
`else
    modport master (
        input  in_valid, in_data,
        output in_ready, ren, raddr, x_out, mac_valid, mac_last, neuron_done, busy
    );
    modport slave (
        output in_valid, in_data,
        input  in_ready, ren, raddr, x_out, mac_valid, mac_last, neuron_done, busy
    );
`endif
endinterface

// File: rtl/wrs_index_counter.sv
// Enabled index counter running 0..LIMIT-1 and wrapping to 0; flags the final index.
// Shared between the read sequencer and the weight write-loader.
module wrs_index_counter
    import weight_read_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = WRS_DEFAULT_NUM_WEIGHT,
    parameter int unsigned WIDTH = wrs_cnt_width(LIMIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last_idx
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign last_idx = (count_q == WIDTH'(LIMIT - 1));
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = last_idx ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/weight_read_sequencer.sv
// Issues one weight read per accepted activation and re-times the activation to meet the
// registered memory output. WRS_BACKPRESSURE_EN lets the MAC stall a presented pair.
module weight_read_sequencer
    import weight_read_sequencer_pkg::*;
#(
    parameter int unsigned numWeight    = WRS_DEFAULT_NUM_WEIGHT,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_read_sequencer_if.master bus
);
    localparam int unsigned CountW = wrs_cnt_width(numWeight);

    wrs_state_e           state_q, state_d;
    logic [dataWidth-1:0] x_q, x_d;
    logic                 mac_valid_q, mac_valid_d;
    logic                 mac_last_q, mac_last_d;
    logic [CountW-1:0]    count;
    logic                 last_idx;
    logic                 pair_taken;
    logic                 in_ready;
    logic                 accept;

    // A presented pair is consumed unless the MAC is stalling it.
`ifdef WRS_BACKPRESSURE_EN
    assign pair_taken = !mac_valid_q || bus.mac_ready;
`else
    assign pair_taken = 1'b1;
`endif

    assign in_ready = ((state_q == WRS_IDLE) || (state_q == WRS_RUN)) && pair_taken;
    assign accept   = bus.in_valid && in_ready;

    wrs_index_counter #(
        .LIMIT (numWeight),
        .WIDTH (CountW)
    ) u_index_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (accept),
        .count    (count),
        .last_idx (last_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            WRS_IDLE, WRS_RUN: begin
                if (accept) begin
                    state_d = last_idx ? WRS_DRAIN : WRS_RUN;
                end
            end
            WRS_DRAIN: begin
                if (pair_taken) begin
                    state_d = WRS_DONE;
                end
            end
            WRS_DONE: state_d = WRS_IDLE;
            default:  state_d = WRS_IDLE;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        mac_valid_d = 1'b0;
        mac_last_d  = 1'b0;
        if (accept) begin
            x_d         = bus.in_data;
            mac_valid_d = 1'b1;
            mac_last_d  = last_idx;
        end else if (!pair_taken) begin
            mac_valid_d = mac_valid_q;
            mac_last_d  = mac_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WRS_IDLE;
            x_q         <= '0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            mac_valid_q <= mac_valid_d;
            mac_last_q  <= mac_last_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.ren         = accept;
    assign bus.raddr       = addressWidth'(count);
    assign bus.x_out       = x_q;
    assign bus.mac_valid   = mac_valid_q;
    assign bus.mac_last    = mac_last_q;
    assign bus.neuron_done = (state_q == WRS_DONE);
    assign bus.busy        = (state_q != WRS_IDLE);
endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed-vector bench for weight_read_sequencer: numWeight=3 and numWeight=1 instances.
module tb_weight_read_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int    checks   = 0;
    int    failures = 0;
    int    step     = 0;
    string test_name = "reset";
`ifdef WRS_BACKPRESSURE_EN
    int    mr_next = 1;
`endif

    always #5 clk = ~clk;

    weight_read_sequencer_if #(.dataWidth(16), .addressWidth(10)) u_if3 ();
    weight_read_sequencer_if #(.dataWidth(16), .addressWidth(10)) u_if1 ();

    weight_read_sequencer #(.numWeight(3), .addressWidth(10), .dataWidth(16)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if3)
    );

    weight_read_sequencer #(.numWeight(1), .addressWidth(10), .dataWidth(16)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s/%0d %s: got %0d expected %0d", test_name, step, tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then check everything 1 time unit later.
    task automatic cyc(input int sel, input int v, input int d,
                       input int e_rdy, input int e_ren, input int e_ra, input int e_x,
                       input int e_mv, input int e_ml, input int e_done, input int e_busy);
        int o_rdy, o_ren, o_ra, o_x, o_mv, o_ml, o_done, o_busy;
        @(negedge clk);
        if (sel == 1) begin
            u_if1.in_valid = v[0];
            u_if1.in_data  = d[15:0];
        end else begin
            u_if3.in_valid = v[0];
            u_if3.in_data  = d[15:0];
`ifdef WRS_BACKPRESSURE_EN
            u_if3.mac_ready = mr_next[0];
`endif
        end
        #1;
        if (sel == 1) begin
            o_rdy = int'(u_if1.in_ready);  o_ren  = int'(u_if1.ren);
            o_ra  = int'(u_if1.raddr);     o_x    = int'(u_if1.x_out);
            o_mv  = int'(u_if1.mac_valid); o_ml   = int'(u_if1.mac_last);
            o_done = int'(u_if1.neuron_done); o_busy = int'(u_if1.busy);
        end else begin
            o_rdy = int'(u_if3.in_ready);  o_ren  = int'(u_if3.ren);
            o_ra  = int'(u_if3.raddr);     o_x    = int'(u_if3.x_out);
            o_mv  = int'(u_if3.mac_valid); o_ml   = int'(u_if3.mac_last);
            o_done = int'(u_if3.neuron_done); o_busy = int'(u_if3.busy);
        end
        step++;
        $display("%s step %0d: in_valid=%0d in_data=%0d in_ready=%0d ren=%0d raddr=%0d x_out=%0d mac_valid=%0d mac_last=%0d done=%0d busy=%0d",
                 test_name, step, v, d, o_rdy, o_ren, o_ra, o_x, o_mv, o_ml, o_done, o_busy);
        chk("in_ready",    o_rdy,  e_rdy);
        chk("ren",         o_ren,  e_ren);
        chk("raddr",       o_ra,   e_ra);
        chk("x_out",       o_x,    e_x);
        chk("mac_valid",   o_mv,   e_mv);
        chk("mac_last",    o_ml,   e_ml);
        chk("neuron_done", o_done, e_done);
        chk("busy",        o_busy, e_busy);
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        u_if3.in_valid = 1'b0;
        u_if1.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_name = name;
        step = 0;
    endtask

    initial begin
        u_if3.in_valid = 1'b0; u_if3.in_data = '0;
        u_if1.in_valid = 1'b0; u_if1.in_data = '0;
`ifdef WRS_BACKPRESSURE_EN
        u_if3.mac_ready = 1'b1;
`endif
        #2;
        chk("raddr",       int'(u_if3.raddr),       0);
        chk("x_out",       int'(u_if3.x_out),       0);
        chk("mac_valid",   int'(u_if3.mac_valid),   0);
        chk("mac_last",    int'(u_if3.mac_last),    0);
        chk("neuron_done", int'(u_if3.neuron_done), 0);
        chk("busy",        int'(u_if3.busy),        0);
        chk("ren",         int'(u_if3.ren),         0);

        // Basic pass, samples 5,6,7 back to back.
        apply_reset("basic");
        //  sel v  d   rdy ren ra  x  mv ml dn by
        cyc(0, 1, 5,   1, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 6,   1, 1, 1,  5, 1, 0, 0, 1);
        cyc(0, 1, 7,   1, 1, 2,  6, 1, 0, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  7, 1, 1, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  7, 0, 0, 1, 1);
        cyc(0, 0, 0,   1, 0, 0,  7, 0, 0, 0, 0);

        // Two-cycle gap after sample 6.
        apply_reset("gap");
        cyc(0, 1, 5,   1, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 6,   1, 1, 1,  5, 1, 0, 0, 1);
        cyc(0, 0, 0,   1, 0, 2,  6, 1, 0, 0, 1);
        cyc(0, 0, 0,   1, 0, 2,  6, 0, 0, 0, 1);
        cyc(0, 1, 7,   1, 1, 2,  6, 0, 0, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  7, 1, 1, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  7, 0, 0, 1, 1);
        cyc(0, 0, 0,   1, 0, 0,  7, 0, 0, 0, 0);

        // Back-to-back passes with in_valid held high.
        apply_reset("b2b");
        cyc(0, 1, 1,   1, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 2,   1, 1, 1,  1, 1, 0, 0, 1);
        cyc(0, 1, 3,   1, 1, 2,  2, 1, 0, 0, 1);
        cyc(0, 1, 4,   0, 0, 0,  3, 1, 1, 0, 1);
        cyc(0, 1, 4,   0, 0, 0,  3, 0, 0, 1, 1);
        cyc(0, 1, 4,   1, 1, 0,  3, 0, 0, 0, 0);
        cyc(0, 1, 5,   1, 1, 1,  4, 1, 0, 0, 1);
        cyc(0, 1, 6,   1, 1, 2,  5, 1, 0, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  6, 1, 1, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  6, 0, 0, 1, 1);
        cyc(0, 0, 0,   1, 0, 0,  6, 0, 0, 0, 0);

        // Reset asserted after the second sample of a pass.
        apply_reset("abort");
        cyc(0, 1, 5,   1, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 6,   1, 1, 1,  5, 1, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        u_if3.in_valid = 1'b0;
        #1;
        step++;
        $display("%s step %0d: reset asserted raddr=%0d x_out=%0d mac_valid=%0d busy=%0d",
                 test_name, step, u_if3.raddr, u_if3.x_out, u_if3.mac_valid, u_if3.busy);
        chk("raddr",       int'(u_if3.raddr),       0);
        chk("x_out",       int'(u_if3.x_out),       0);
        chk("mac_valid",   int'(u_if3.mac_valid),   0);
        chk("mac_last",    int'(u_if3.mac_last),    0);
        chk("neuron_done", int'(u_if3.neuron_done), 0);
        chk("busy",        int'(u_if3.busy),        0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 8,   1, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, 0, 0,   1, 0, 1,  8, 1, 0, 0, 1);
        cyc(0, 0, 0,   1, 0, 1,  8, 0, 0, 0, 1);

        // Single-weight neuron.
        apply_reset("nw1");
        cyc(1, 1, 9,   1, 1, 0,  0, 0, 0, 0, 0);
        cyc(1, 0, 0,   0, 0, 0,  9, 1, 1, 0, 1);
        cyc(1, 0, 0,   0, 0, 0,  9, 0, 0, 1, 1);
        cyc(1, 0, 0,   1, 0, 0,  9, 0, 0, 0, 0);

`ifdef WRS_BACKPRESSURE_EN
        // MAC stalls the second pair for three cycles.
        apply_reset("bp");
        mr_next = 1;
        cyc(0, 1, 5,   1, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, 1, 6,   1, 1, 1,  5, 1, 0, 0, 1);
        mr_next = 0;
        cyc(0, 1, 7,   0, 0, 2,  6, 1, 0, 0, 1);
        cyc(0, 1, 7,   0, 0, 2,  6, 1, 0, 0, 1);
        cyc(0, 1, 7,   0, 0, 2,  6, 1, 0, 0, 1);
        mr_next = 1;
        cyc(0, 1, 7,   1, 1, 2,  6, 1, 0, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  7, 1, 1, 0, 1);
        cyc(0, 0, 0,   0, 0, 0,  7, 0, 0, 1, 1);
        cyc(0, 0, 0,   1, 0, 0,  7, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
